// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter: shares one register-file write port between the         |
// | pipeline writeback and a buffered long-latency unit result stream.        |
// | Optional macro WB_ARB_STARVE_GUARD_EN: forced drain of a starved head.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pipe_valid,
  input  logic [4:0]            i_pipe_wbs,
  input  logic [31:0]           i_pipe_wbd,
  input  logic                  i_pipe_wbv,
  output logic                  o_pipe_stall,
  input  logic                  i_lu_valid,
  input  logic [4:0]            i_lu_wbs,
  input  logic [31:0]           i_lu_wbd,
  output logic                  o_lu_ready,
  output logic                  o_rf_we,
  output logic [4:0]            o_rf_waddr,
  output logic [31:0]           o_rf_wdata,
  output logic [FIFO_DEPTH-1:0] o_lu_pending
);
  localparam int            c_AW   = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_NORMAL = 2'd0,
    S_DRAIN  = 2'd1,
    S_FORCE  = 2'd2
  } state_t;

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 8) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (STARVE_LIMIT < 1)) begin : g_param_chk
    $error("wb_port_arbiter: illegal FIFO_DEPTH or STARVE_LIMIT");
  end

  state_t                r_state;
  logic                  r_stall;
  logic [4:0]            r_wbs [FIFO_DEPTH];
  logic [31:0]           r_wbd [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_live;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW:0]         r_count;
  logic [c_AW:0]         w_count_nxt;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pipe_wants;
  logic                  w_pipe_go;
  logic                  w_pop;
  logic                  w_head_live;
  logic                  w_kill;
  logic                  w_push_live;
  logic                  w_force_go;

  always_comb begin
    w_full       = (r_count == c_FULL);
    w_push       = i_lu_valid && !w_full;
    w_pipe_wants = i_pipe_valid && i_pipe_wbv;
    w_pipe_go    = w_pipe_wants && !r_stall;
    w_pop        = (r_count != '0) && (r_stall || !w_pipe_wants);
    w_head_live  = r_live[r_rd_ptr];
    w_kill       = w_pipe_go && (i_pipe_wbs != 5'd0);
    // An lu result arriving alongside a pipeline write to the same register is older: drop it.
    w_push_live  = (i_lu_wbs != 5'd0) && !(w_kill && (i_lu_wbs == i_pipe_wbs));
    w_count_nxt  = r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
  end

  assign o_pipe_stall = r_stall;
  assign o_lu_ready   = !w_full;
  assign o_rf_we      = rst_n && (w_kill || (w_pop && w_head_live));
  assign o_rf_waddr   = w_pipe_go ? i_pipe_wbs : r_wbs[r_rd_ptr];
  assign o_rf_wdata   = w_pipe_go ? i_pipe_wbd : r_wbd[r_rd_ptr];
  assign o_lu_pending = r_live;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wbs[r_wr_ptr] <= i_lu_wbs;
      r_wbd[r_wr_ptr] <= i_lu_wbd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_push && (r_wr_ptr == c_AW'(i))) begin
          r_live[i] <= w_push_live;
        end else if ((w_pop && (r_rd_ptr == c_AW'(i))) ||
                     (w_kill && r_live[i] && (r_wbs[i] == i_pipe_wbs))) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int              c_SW          = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SW-1:0] c_STARVE_LAST = c_SW'(STARVE_LIMIT - 1);

  logic [c_SW-1:0] r_starve;
  logic            w_blocked;

  assign w_blocked  = (r_state == S_NORMAL) && (r_count != '0) && w_head_live && w_pipe_wants;
  assign w_force_go = w_blocked && (r_starve == c_STARVE_LAST) && !(w_full && i_lu_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!w_blocked || w_force_go || (w_full && i_lu_valid)) begin
      r_starve <= '0;
    end else begin
      r_starve <= r_starve + c_SW'(1);
    end
  end
`else
  assign w_force_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_NORMAL;
      r_stall <= 1'b0;
    end else begin
      case (r_state)
        S_NORMAL: begin
          if (w_full && i_lu_valid) begin
            r_state <= S_DRAIN;
            r_stall <= 1'b1;
          end else if (w_force_go) begin
            r_state <= S_FORCE;
            r_stall <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_count_nxt == '0) begin
            r_state <= S_NORMAL;
            r_stall <= 1'b0;
          end
        end
        default: begin
          r_state <= S_NORMAL;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
